interfaz_tx: RTL

Transmit-side counterpart of the ALU receive interface. It captures each ALU result byte on its valid pulse into a small FIFO. It then hands the bytes one at a time to the UART transmitter, using a start/done handshake. It sits between the ALU result path and the UART TX serializer, so result bursts never need back-pressure on the ALU.

---
 rtl/interfaz_tx_if.sv | 39 +++
 rtl/interfaz_tx.sv | 122 ++++++++++++
 2 files changed

// File: rtl/interfaz_tx_if.sv
// Bundle of the ALU-result / UART-TX handshake signals seen by interfaz_tx.
// The master side is the surrounding logic (ALU result path and UART TX);
// the slave side is the interfaz_tx block itself.
interface interfaz_tx_if #(
  parameter int NB_DATA = 8
);

  logic               i_valid;
  logic [NB_DATA-1:0] i_result;
  logic               i_tx_done;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_busy;
  logic               o_full;
  logic               o_overflow;

  modport master (
    output i_valid,
    output i_result,
    output i_tx_done,
    input  o_tx_start,
    input  o_tx_data,
    input  o_busy,
    input  o_full,
    input  o_overflow
  );

  modport slave (
    input  i_valid,
    input  i_result,
    input  i_tx_done,
    output o_tx_start,
    output o_tx_data,
    output o_busy,
    output o_full,
    output o_overflow
  );

endinterface

// File: rtl/interfaz_tx.sv
// Transmit-side interface: buffers ALU result bytes in a small FIFO and hands
// them one at a time to the UART TX using a start/done handshake, so bursts of
// results never have to stall the ALU.
module interfaz_tx #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 2
) (
  input  logic          i_clock,
  input  logic          i_reset,
  interfaz_tx_if.slave  bus_if
);

  localparam int                 DEPTH   = 2 ** NB_ADDR;
  localparam logic [NB_ADDR:0]   DEPTH_C = (NB_ADDR + 1)'(DEPTH);
  localparam logic [NB_ADDR:0]   CNT_ONE = (NB_ADDR + 1)'(1);
  localparam logic [NB_ADDR-1:0] PTR_ONE = NB_ADDR'(1);

  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    LOAD      = 4'b0010,
    START     = 4'b0100,
    WAIT_DONE = 4'b1000
  } state_t;

  state_t               state_q;
  logic [NB_ADDR-1:0]   wr_ptr_q;
  logic [NB_ADDR-1:0]   rd_ptr_q;
  logic [NB_ADDR:0]     count_q;
  logic [NB_ADDR:0]     count_d;
  logic [NB_DATA-1:0]   mem_q [DEPTH];
  logic [NB_DATA-1:0]   tx_data_q;
  logic                 overflow_q;

  logic                 pop;
  logic                 push;
  logic                 drop;

  // A pop only happens while loading a byte for the serializer; the count
  // guard keeps a corrupted state from underflowing the FIFO.
  assign pop  = (state_q == LOAD) && (count_q != '0);
  // A full FIFO still accepts a byte when a slot frees up on the same edge.
  assign push = bus_if.i_valid && ((count_q != DEPTH_C) || pop);
  assign drop = bus_if.i_valid && !push;

  // Occupancy after the current edge; WAIT_DONE uses it to decide between
  // going straight to LOAD or back to IDLE.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // FIFO storage: plain array with no reset so it maps to RAM.
  always_ff @(posedge i_clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus_if.i_result;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Handshake FSM with the registered output byte; the byte is read from the
  // FIFO on the edge leaving LOAD so it is stable for the whole frame.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          tx_data_q <= mem_q[rd_ptr_q];
          state_q   <= START;
        end
        START: begin
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus_if.i_tx_done) begin
            state_q <= (count_d != '0) ? LOAD : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_if.o_tx_start = (state_q == START);
  assign bus_if.o_tx_data  = tx_data_q;
  assign bus_if.o_busy     = (state_q != IDLE) || (count_q != '0);
  assign bus_if.o_full     = (count_q == DEPTH_C);
  assign bus_if.o_overflow = overflow_q;

endmodule
